dts_search_engine: RTL and testbench

- Parametrised successor to the fixed-size DTS search worker.
- Exhaustive backtracking search for (n,k) difference triangle sets: n rulers, k marks each, mark 0 implicit, largest mark <= M, all positive in-ruler differences distinct across the whole set.
- Enumerates every solution in order via a valid/ack handshake rather than stopping at the first one, and reports exhaustion.
- Sits under the search farm controller, which issues start and drains solutions.

---
 rtl/dts_search_engine.sv | 185 ++++++++++++++++++
 tb/tb_dts_search_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dts_search_engine.sv
// Exhaustive backtracking enumerator for (N,K) difference triangle sets with marks <= M.
// One candidate per TRY cycle; each solution is held in FOUND until the consumer acks it.
module dts_search_engine #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int M  = 19,
    parameter int CW = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sol_ack,
    output logic [N*(M+1)-1:0] res,
    output logic               sol_valid,
    output logic               busy,
    output logic               done,
    output logic [CW-1:0]      sol_count
);

    localparam int KM  = K - 1;
    localparam int D   = N * KM;
    localparam int W   = $clog2(M + 2);
    localparam int DW  = (D > 1) ? $clog2(D) : 1;
    localparam int SD  = 1 << DW;
    localparam int BMW = 1 << W;
    localparam int RW  = N * (M + 1);

    typedef enum logic [1:0] {S_IDLE, S_TRY, S_FOUND, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   d_q, d_d;
    logic [W-1:0]    c_q, c_d;
    logic [W-1:0]    stack_q [SD];
    logic [W-1:0]    stack_d [SD];
    logic [BMW-1:0]  used_q, used_d;
    logic [RW-1:0]   res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    int              cur_d, cur_b, cur_p;
    int              pop_d, pop_b, pop_p;
    logic            fits;
    logic            do_push, do_pop;
    logic [W-1:0]    diff_t;
    logic [W-1:0]    pop_mark;
    logic [W-1:0]    first_mark;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            c_q     <= '0;
            used_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < SD; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            c_q     <= c_d;
            used_q  <= used_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < SD; i++) stack_q[i] <= stack_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        c_d     = c_q;
        used_d  = used_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < SD; i++) stack_d[i] = stack_q[i];
        do_push = 1'b0;
        do_pop  = 1'b0;
        diff_t  = '0;

        cur_d = int'(d_q);
        cur_b = cur_d / KM;
        cur_p = cur_d % KM;

        // Candidate fits if its distance to 0 and to every earlier mark of its ruler is unused.
        fits = (c_q <= W'(M)) && !used_q[c_q];
        for (int i = 0; i < KM; i++) begin
            if (i < cur_p) begin
                diff_t = c_q - stack_q[DW'(cur_b * KM + i)];
                if (used_q[diff_t]) fits = 1'b0;
            end
        end

        // FOUND pops the full-depth top entry; TRY pops the entry below the current depth.
        pop_d    = (state_q == S_FOUND) ? cur_d : cur_d - 1;
        pop_b    = pop_d / KM;
        pop_p    = pop_d % KM;
        pop_mark = stack_q[DW'(pop_d)];

        first_mark = (cur_p == 0) ? c_q : stack_q[DW'(cur_b * KM)];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_TRY;
                    d_d     = '0;
                    c_d     = W'(1);
                    used_d  = '0;
                    res_d   = '0;
                    cnt_d   = '0;
                    for (int i = 0; i < SD; i++) stack_d[i] = '0;
                end
            end
            S_TRY: begin
                if (c_q > W'(M)) begin
                    if (d_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        do_pop = 1'b1;
                        d_d    = d_q - DW'(1);
                    end
                end else if (fits) begin
                    do_push = 1'b1;
                    if (cur_d == D - 1) begin
                        state_d = S_FOUND;
                    end else begin
                        d_d = d_q + DW'(1);
                        // A new ruler starts above the previous ruler's first mark (symmetry breaking).
                        c_d = (cur_p == KM - 1) ? first_mark + W'(1) : c_q + W'(1);
                    end
                end else begin
                    c_d = c_q + W'(1);
                end
            end
            S_FOUND: begin
                if (sol_ack) begin
                    do_pop  = 1'b1;
                    state_d = S_TRY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_pop) begin
            c_d              = pop_mark + W'(1);
            used_d[pop_mark] = 1'b0;
            for (int i = 0; i < KM; i++) begin
                if (i < pop_p) begin
                    diff_t         = pop_mark - stack_q[DW'(pop_b * KM + i)];
                    used_d[diff_t] = 1'b0;
                end
            end
        end

        if (do_push) begin
            stack_d[d_q] = c_q;
            used_d[c_q]  = 1'b1;
            for (int i = 0; i < KM; i++) begin
                if (i < cur_p) begin
                    diff_t         = c_q - stack_q[DW'(cur_b * KM + i)];
                    used_d[diff_t] = 1'b1;
                end
            end
            if (cur_d == D - 1) begin
                res_d = '0;
                for (int b = 0; b < N; b++) begin
                    res_d[b * (M + 1)] = 1'b1;
                    for (int j = 1; j <= M; j++) begin
                        for (int i = 0; i < KM; i++) begin
                            if (stack_d[b * KM + i] == W'(j)) res_d[b * (M + 1) + j] = 1'b1;
                        end
                    end
                end
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        busy      = (state_q == S_TRY) || (state_q == S_FOUND);
        done      = (state_q == S_DONE);
        sol_valid = (state_q == S_FOUND);
        res       = res_q;
        sol_count = cnt_q;
    end

endmodule

// File: tb/tb_dts_search_engine.sv
// Bench for dts_search_engine: four instances of different sizes, solutions checked in order
// against a brute-force enumeration of all mark tuples in lexicographic order.
module tb_dts_search_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_v;
    logic [3:0] start_v;
    logic [3:0] ack_v;
    int         sel;

    logic [3:0]  a_res;
    logic [15:0] b_res;
    logic [11:0] c_res;
    logic [41:0] d_res;
    logic [3:0]  v_valid, v_busy, v_done;
    logic [15:0] a_cnt, b_cnt, c_cnt, d_cnt;

    dts_search_engine #(.N(1), .K(3), .M(3), .CW(16)) u_a (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .sol_ack(ack_v[0]),
        .res(a_res), .sol_valid(v_valid[0]), .busy(v_busy[0]), .done(v_done[0]), .sol_count(a_cnt));
    dts_search_engine #(.N(2), .K(3), .M(7), .CW(16)) u_b (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .sol_ack(ack_v[1]),
        .res(b_res), .sol_valid(v_valid[1]), .busy(v_busy[1]), .done(v_done[1]), .sol_count(b_cnt));
    dts_search_engine #(.N(2), .K(3), .M(5), .CW(16)) u_c (
        .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .sol_ack(ack_v[2]),
        .res(c_res), .sol_valid(v_valid[2]), .busy(v_busy[2]), .done(v_done[2]), .sol_count(c_cnt));
    // Three-ruler instance with a reduced mark limit so the full enumeration stays short.
    dts_search_engine #(.N(3), .K(3), .M(13), .CW(16)) u_d (
        .clk(clk), .reset(rst_v[3]), .start(start_v[3]), .sol_ack(ack_v[3]),
        .res(d_res), .sol_valid(v_valid[3]), .busy(v_busy[3]), .done(v_done[3]), .sol_count(d_cnt));

    logic [63:0] cur_res;
    logic [15:0] cur_count;
    logic        cur_valid, cur_busy, cur_done;

    always_comb begin
        cur_valid = v_valid[sel];
        cur_busy  = v_busy[sel];
        cur_done  = v_done[sel];
        case (sel)
            0:       begin cur_res = 64'(a_res); cur_count = a_cnt; end
            1:       begin cur_res = 64'(b_res); cur_count = b_cnt; end
            2:       begin cur_res = 64'(c_res); cur_count = c_cnt; end
            default: begin cur_res = 64'(d_res); cur_count = d_cnt; end
        endcase
    end

    logic [63:0] exp_q[$];
    int          exp_n;
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_start;
        start_v[sel] = 1'b1;
        step();
        start_v[sel] = 1'b0;
    endtask

    task automatic pulse_ack;
        ack_v[sel] = 1'b1;
        step();
        ack_v[sel] = 1'b0;
    endtask

    // Enumerate every tuple of marks in 1..m, keep the valid ordered DTS ones.
    task automatic gen_model(input int n, input int k, input int m);
        int          d;
        int          t[16];
        logic [63:0] usedb;
        logic [63:0] r;
        bit          ok, more;
        int          base, dd, pos;
        exp_q.delete();
        d = n * (k - 1);
        for (int i = 0; i < d; i++) t[i] = 1;
        more = 1'b1;
        while (more) begin
            ok    = 1'b1;
            usedb = '0;
            for (int b = 0; b < n; b++) begin
                base = b * (k - 1);
                if (b > 0 && t[base] <= t[base - (k - 1)]) ok = 1'b0;
                for (int i = 0; i < k - 1; i++) begin
                    if (i > 0 && t[base + i] <= t[base + i - 1]) ok = 1'b0;
                end
                if (ok) begin
                    for (int i = 0; i < k - 1; i++) begin
                        dd = t[base + i];
                        if (usedb[dd]) ok = 1'b0;
                        usedb[dd] = 1'b1;
                        for (int j = 0; j < i; j++) begin
                            dd = t[base + i] - t[base + j];
                            if (usedb[dd]) ok = 1'b0;
                            usedb[dd] = 1'b1;
                        end
                    end
                end
            end
            if (ok) begin
                r = '0;
                for (int b = 0; b < n; b++) begin
                    r[b * (m + 1)] = 1'b1;
                    for (int i = 0; i < k - 1; i++) r[b * (m + 1) + t[b * (k - 1) + i]] = 1'b1;
                end
                exp_q.push_back(r);
            end
            pos = d - 1;
            while (pos >= 0) begin
                t[pos]++;
                if (t[pos] <= m) break;
                t[pos] = 1;
                pos--;
            end
            if (pos < 0) more = 1'b0;
        end
        exp_n = exp_q.size();
    endtask

    task automatic wait_valid(input int budget);
        int cyc = 0;
        while (!cur_valid && cyc < budget) begin
            step();
            cyc++;
        end
        check("wait_valid", 64'(cur_valid), 64'(1));
    endtask

    // Drain every solution with an ack until done, comparing against the expected queue.
    task automatic collect(input int budget);
        int cyc = 0;
        int got = 0;
        bit fin = 1'b0;
        while (!fin) begin
            if (cur_valid) begin
                got++;
                if (exp_q.size() > 0) check("sol_res", cur_res, exp_q.pop_front());
                else check("extra_sol", 64'(got), 64'(exp_n));
                check("sol_count", 64'(cur_count), 64'(got));
                pulse_ack();
            end else if (cur_done) begin
                fin = 1'b1;
            end else begin
                step();
                cyc++;
                if (cyc > budget) begin
                    check("timeout", 64'(cyc), 64'(budget));
                    fin = 1'b1;
                end
            end
        end
        check("left_in_queue", 64'(exp_q.size()), 64'(0));
        check("final_count", 64'(cur_count), 64'(exp_n));
        check("final_done", 64'(cur_done), 64'(1));
        check("final_valid", 64'(cur_valid), 64'(0));
        check("final_busy", 64'(cur_busy), 64'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_res"}, cur_res, 64'(0));
        check({tag, "_valid"}, 64'(cur_valid), 64'(0));
        check({tag, "_busy"}, 64'(cur_busy), 64'(0));
        check({tag, "_done"}, 64'(cur_done), 64'(0));
        check({tag, "_count"}, 64'(cur_count), 64'(0));
    endtask

    initial begin
        sel     = 0;
        rst_v   = 4'hF;
        start_v = 4'h0;
        ack_v   = 4'h0;
        step();
        step();
        check_zero("reset_a");
        sel = 3;
        check_zero("reset_d");
        rst_v = 4'h0;
        step();

        // Single ruler, two solutions {0,1,3} then {0,2,3}.
        sel = 0;
        gen_model(1, 3, 3);
        pulse_start();
        collect(500);

        // Two rulers, M=7: first solution, hold without ack.
        sel = 1;
        pulse_start();
        wait_valid(2000);
        check("b_first_res", cur_res, 64'h8513);
        check("b_first_count", 64'(cur_count), 64'(1));
        for (int i = 0; i < 10; i++) begin
            step();
            check("b_hold_res", cur_res, 64'h8513);
            check("b_hold_valid", 64'(cur_valid), 64'(1));
        end

        // Asynchronous reset while holding a solution, then while searching.
        #2;
        rst_v[1] = 1'b1;
        #1;
        check_zero("rst_found");
        step();
        rst_v[1] = 1'b0;
        step();
        pulse_start();
        step();
        step();
        check("b_try_busy", 64'(cur_busy), 64'(1));
        #2;
        rst_v[1] = 1'b1;
        #1;
        check_zero("rst_try");
        step();
        rst_v[1] = 1'b0;
        step();

        // Fresh search disturbed by start and ack while in TRY; sequence must be unchanged.
        gen_model(2, 3, 7);
        pulse_start();
        step();
        check("b_dist_busy", 64'(cur_busy), 64'(1));
        check("b_dist_valid", 64'(cur_valid), 64'(0));
        pulse_start();
        pulse_ack();
        collect(20000);

        // Restart after done.
        pulse_start();
        wait_valid(2000);
        check("b_restart_res", cur_res, 64'h8513);
        check("b_restart_count", 64'(cur_count), 64'(1));

        // Too small to hold any solution.
        sel = 2;
        gen_model(2, 3, 5);
        pulse_start();
        collect(20000);

        // Three rulers, full enumeration.
        sel = 3;
        gen_model(3, 3, 13);
        pulse_start();
        collect(70000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
